// File: rtl/cpu_seq_if.sv
// -----------------------------------------------------------------------------
// cpu_seq_if
// Groups the handshake, decoder, strobe and status signals that run between
// the multi-cycle sequencer and the datapath it controls.
//
// Signals:
//   run          datapath -> seq   1 = execute, 0 = stop at next boundary
//   imem_ready   datapath -> seq   instruction memory has valid ins
//   dmem_ready   datapath -> seq   data memory completed the access
//   is_load, is_store, is_halt, wren
//                datapath -> seq   decoder outputs, valid from DECODE on
//   imem_req     seq -> datapath   fetch request
//   ir_we        seq -> datapath   latch ins into the instruction register
//   pc_we        seq -> datapath   advance the PC
//   rf_we        seq -> datapath   register-file write strobe
//   dmem_re      seq -> datapath   data-memory read request
//   dmem_we      seq -> datapath   data-memory write request
//   halted       seq -> datapath   sticky halt indicator
//   fault        seq -> datapath   sticky memory-timeout indicator
//   state[2:0]   seq -> datapath   current state encoding
//   cycle_cnt    seq -> datapath   active-cycle counter
//   instret_cnt  seq -> datapath   retired-instruction counter
//
// Modports: master = sequencer side, slave = datapath side.
// -----------------------------------------------------------------------------
interface cpu_seq_if;
    logic        run;
    logic        imem_ready;
    logic        dmem_ready;
    logic        is_load;
    logic        is_store;
    logic        is_halt;
    logic        wren;
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic        rf_we;
    logic        dmem_re;
    logic        dmem_we;
    logic        halted;
    logic        fault;
    logic [2:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    modport master (
        input  run, imem_ready, dmem_ready, is_load, is_store, is_halt, wren,
        output imem_req, ir_we, pc_we, rf_we, dmem_re, dmem_we,
               halted, fault, state, cycle_cnt, instret_cnt
    );

    modport slave (
        output run, imem_ready, dmem_ready, is_load, is_store, is_halt, wren,
        input  imem_req, ir_we, pc_we, rf_we, dmem_re, dmem_we,
               halted, fault, state, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/cpu_seq.sv
// -----------------------------------------------------------------------------
// cpu_seq
// Multi-cycle sequencer: steps each instruction through FETCH, DECODE, EXEC,
// MEM and WB, generating PC / IR / register-file / data-memory strobes and
// waiting on the memory-ready handshakes. Stops permanently (until reset) on
// a halt instruction or a memory timeout.
//
// Parameters:
//   MEM_TIMEOUT  max wait-counter value in FETCH/MEM before faulting (1..255)
//
// Ports:
//   clk   core clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   cpu_seq_if.master: decoder/handshake inputs, strobes, status
//
// Optional feature:
//   PERF_CNT_EN  when defined, builds the 32-bit cycle_cnt / instret_cnt
//                counters; otherwise both outputs are tied to 0.
// -----------------------------------------------------------------------------
module cpu_seq #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst,
    cpu_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_next;

    logic w_imem_req;
    logic w_ir_we;
    logic w_pc_we;
    logic w_rf_we;
    logic w_dmem_re;
    logic w_dmem_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    // The wait counter only survives a cycle in which FETCH/MEM is re-entered
    // by waiting; any other transition (including entry) leaves it at 0.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = '0;
        w_imem_req   = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_rf_we      = 1'b0;
        w_dmem_re    = 1'b0;
        w_dmem_we    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                // Ready wins even on the final allowed cycle.
                if (bus.imem_ready) begin
                    w_ir_we      = 1'b1;
                    w_state_next = S_DECODE;
                end else if (r_wait_cnt == TIMEOUT) begin
                    w_state_next = S_FAULT;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                w_state_next = bus.is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                w_state_next = (bus.is_load | bus.is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // A store takes priority when the decoder flags both.
                w_dmem_we = bus.is_store;
                w_dmem_re = bus.is_load & ~bus.is_store;
                if (bus.dmem_ready) begin
                    w_state_next = S_WB;
                end else if (r_wait_cnt == TIMEOUT) begin
                    w_state_next = S_FAULT;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                end
            end
            S_WB: begin
                w_pc_we      = 1'b1;
                w_rf_we      = bus.wren;
                w_state_next = bus.run ? S_FETCH : S_IDLE;
            end
            S_HALT:  w_state_next = S_HALT;
            S_FAULT: w_state_next = S_FAULT;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.imem_req = w_imem_req;
    assign bus.ir_we    = w_ir_we;
    assign bus.pc_we    = w_pc_we;
    assign bus.rf_we    = w_rf_we;
    assign bus.dmem_re  = w_dmem_re;
    assign bus.dmem_we  = w_dmem_we;
    // HALT/FAULT are terminal states, so decoding them is already sticky.
    assign bus.halted   = (r_state == S_HALT);
    assign bus.fault    = (r_state == S_FAULT);
    assign bus.state    = r_state;

`ifdef PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB})
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (r_state == S_WB)
                r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign bus.cycle_cnt   = r_cycle_cnt;
    assign bus.instret_cnt = r_instret_cnt;
`else
    assign bus.cycle_cnt   = '0;
    assign bus.instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_seq
// Scoreboard bench for cpu_seq (MEM_TIMEOUT=4). The stimulus process drives
// one cycle of inputs at a time and pushes the hand-computed state, strobe
// vector and counter values expected for that cycle; a monitor pops and
// compares on each falling edge.
// Strobe vector: {imem_req, ir_we, pc_we, rf_we, dmem_re, dmem_we, halted, fault}
// Input vector : {run, imem_ready, dmem_ready, is_load, is_store, is_halt, wren}
// -----------------------------------------------------------------------------
module tb_cpu_seq;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2,
                           EXEC = 3'd3, MEM = 3'd4, WB = 3'd5,
                           HALT = 3'd6, FAULT = 3'd7;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  strb;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    logic clk;
    logic rst;

    cpu_seq_if bus();

    cpu_seq #(.MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  sb_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_txn    = 0;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    // Monitor: compares each presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic [7:0] got;
            e   = sb_q.pop_front();
            nm  = name_q.pop_front();
            got = {bus.imem_req, bus.ir_we, bus.pc_we, bus.rf_we,
                   bus.dmem_re, bus.dmem_we, bus.halted, bus.fault};
            n_txn++;
            $display("txn %0d %s: state=%0d strobes=%b cyc=%0d ins=%0d",
                     n_txn, nm, bus.state, got, bus.cycle_cnt, bus.instret_cnt);
            n_checks++;
            if (bus.state !== e.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d want %0d", nm, bus.state, e.st);
            end
            n_checks++;
            if (got !== e.strb) begin
                n_fail++;
                $display("FAIL %s strobes: got %b want %b", nm, got, e.strb);
            end
            n_checks++;
            if (bus.cycle_cnt !== e.cyc) begin
                n_fail++;
                $display("FAIL %s cycle_cnt: got %0d want %0d", nm, bus.cycle_cnt, e.cyc);
            end
            n_checks++;
            if (bus.instret_cnt !== e.ins) begin
                n_fail++;
                $display("FAIL %s instret_cnt: got %0d want %0d", nm, bus.instret_cnt, e.ins);
            end
        end
    end

    task automatic set_in(input logic [6:0] in);
        {bus.run, bus.imem_ready, bus.dmem_ready, bus.is_load,
         bus.is_store, bus.is_halt, bus.wren} = in;
    endtask

    task automatic push(input logic [2:0] es, input logic [7:0] eb, input string nm);
        exp_t e;
        e.st   = es;
        e.strb = eb;
        e.cyc  = PERF ? m_cyc : 32'd0;
        e.ins  = PERF ? m_ins : 32'd0;
        sb_q.push_back(e);
        name_q.push_back(nm);
        if (es >= FETCH && es <= WB) m_cyc = m_cyc + 32'd1;
        if (es == WB)                m_ins = m_ins + 32'd1;
    endtask

    // One cycle: drive inputs just after the rising edge, queue expectation.
    task automatic cyc(input logic [6:0] in, input logic [2:0] es,
                       input logic [7:0] eb, input string nm);
        set_in(in);
        push(es, eb, nm);
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle; the falling-edge sample must already be IDLE.
    task automatic do_reset(input string nm);
        rst = 1'b0;
        set_in(7'b0);
        m_cyc = 32'd0;
        m_ins = 32'd0;
        push(IDLE, 8'h00, nm);
        m_cyc = 32'd0;
        m_ins = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        m_cyc = 32'd0;
        m_ins = 32'd0;
        set_in(7'b0);
        @(posedge clk);
        #1;
        do_reset("reset");

        // Three ALU instructions with wren=1, zero-wait memory.
        cyc(7'b1100001, IDLE, 8'h00, "alu_idle");
        for (int i = 0; i < 3; i++) begin
            cyc(7'b1100001, FETCH,  8'hC0, "alu_fetch");
            cyc(7'b1100001, DECODE, 8'h00, "alu_decode");
            cyc(7'b1100001, EXEC,   8'h00, "alu_exec");
            cyc(7'b1100001, WB,     8'h30, "alu_wb");
        end

        // Load with dmem_ready low for three cycles.
        cyc(7'b1101001, FETCH,  8'hC0, "ld_fetch");
        cyc(7'b1101001, DECODE, 8'h00, "ld_decode");
        cyc(7'b1101001, EXEC,   8'h00, "ld_exec");
        for (int i = 0; i < 3; i++)
            cyc(7'b1101001, MEM, 8'h08, "ld_mem_wait");
        cyc(7'b1111001, MEM,    8'h08, "ld_mem_ready");
        cyc(7'b1111001, WB,     8'h30, "ld_wb");

        // Store with is_load also set: store wins.
        cyc(7'b1111100, FETCH,  8'hC0, "stld_fetch");
        cyc(7'b1111100, DECODE, 8'h00, "stld_decode");
        cyc(7'b1111100, EXEC,   8'h00, "stld_exec");
        cyc(7'b1111100, MEM,    8'h04, "stld_mem");
        cyc(7'b1111100, WB,     8'h20, "stld_wb");

        // run dropped during EXEC: finish through WB, then IDLE.
        cyc(7'b1100000, FETCH,  8'hC0, "rd_fetch");
        cyc(7'b1100000, DECODE, 8'h00, "rd_decode");
        cyc(7'b0100000, EXEC,   8'h00, "rd_exec");
        cyc(7'b0100000, WB,     8'h20, "rd_wb");
        cyc(7'b0100000, IDLE,   8'h00, "rd_idle");
        cyc(7'b1100000, IDLE,   8'h00, "rd_idle_run");

        // Fetch wait: ready arrives on the 5th (last allowed) cycle.
        for (int i = 0; i < 4; i++)
            cyc(7'b1000000, FETCH, 8'h80, "fw_wait");
        cyc(7'b1100000, FETCH,  8'hC0, "fw_ready_last");
        cyc(7'b1100000, DECODE, 8'h00, "fw_decode");
        cyc(7'b1100000, EXEC,   8'h00, "fw_exec");
        cyc(7'b1100000, WB,     8'h20, "fw_wb");

        // Halt: sticky regardless of run.
        cyc(7'b1100010, FETCH,  8'hC0, "h_fetch");
        cyc(7'b1100010, DECODE, 8'h00, "h_decode");
        cyc(7'b0100010, HALT,   8'h02, "h_halt0");
        cyc(7'b1100010, HALT,   8'h02, "h_halt1");
        cyc(7'b0100000, HALT,   8'h02, "h_halt2");
        cyc(7'b1100000, HALT,   8'h02, "h_halt3");
        do_reset("h_reset");

        // Fetch timeout: 5 cycles waiting, then FAULT forever.
        cyc(7'b1000000, IDLE, 8'h00, "to_idle");
        for (int i = 0; i < 5; i++)
            cyc(7'b1000000, FETCH, 8'h80, "to_wait");
        cyc(7'b1100000, FAULT, 8'h01, "to_fault0");
        cyc(7'b0111111, FAULT, 8'h01, "to_fault1");
        cyc(7'b1000000, FAULT, 8'h01, "to_fault2");
        do_reset("to_reset");

        // Reset during a pending store: strobes drop asynchronously.
        cyc(7'b1100100, IDLE,   8'h00, "ar_idle");
        cyc(7'b1100100, FETCH,  8'hC0, "ar_fetch");
        cyc(7'b1100100, DECODE, 8'h00, "ar_decode");
        cyc(7'b1100100, EXEC,   8'h00, "ar_exec");
        cyc(7'b1100100, MEM,    8'h04, "ar_mem");
        do_reset("ar_reset_in_mem");

        // Recovery after reset.
        cyc(7'b1100001, IDLE,   8'h00, "rc_idle");
        cyc(7'b1100001, FETCH,  8'hC0, "rc_fetch");
        cyc(7'b1100001, DECODE, 8'h00, "rc_decode");
        cyc(7'b1100001, EXEC,   8'h00, "rc_exec");
        cyc(7'b1100001, WB,     8'h30, "rc_wb");
        cyc(7'b0100000, FETCH,  8'hC0, "rc_fetch2");

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++)
            @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
# cpu_seq

Multi-cycle sequencer for the core datapath (pc, instruction memory, decoder, ALU, register file, data memory). It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It generates the write and enable strobes for the PC, instruction register, register file and data memory, waits on memory-ready handshakes, and stops on a halt instruction or a memory timeout. It sits beside the datapath in `cpu` and replaces implicit single-cycle sequencing.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: maximum wait-counter value in FETCH/MEM before the block faults; legal range 1..255.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- run  input  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- imem_ready  input  1  instruction memory has valid `ins` this cycle.
- dmem_ready  input  1  data memory has completed the load/store this cycle.
- is_load, is_store, is_halt, wren  input  1 each  decoder outputs; valid from DECODE onward.
- imem_req  output  1  fetch request.
- ir_we  output  1  latch `ins` into the instruction register.
- pc_we  output  1  advance the PC.
- rf_we  output  1  register-file write strobe.
- dmem_re  output  1  data-memory read request.
- dmem_we  output  1  data-memory write request.
- halted  output  1  sticky halt indicator.
- fault  output  1  sticky timeout indicator.
- state  output  3  current state encoding.
- cycle_cnt  output  32  active-cycle counter; see Configuration.
- instret_cnt  output  32  retired-instruction counter; see Configuration.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE:
  - run=1 → FETCH.
  - All strobes 0.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_we=1 in the same cycle (Mealy), next state DECODE.
- DECODE:
  - is_halt=1 → HALT.
  - Otherwise → EXEC.
- EXEC:
  - (is_load|is_store)=1 → MEM.
  - Otherwise → WB.
- MEM:
  - dmem_we=is_store and dmem_re=is_load&~is_store; a store takes priority if both are set.
  - Requests are held until dmem_ready=1, then next state WB.
- WB:
  - rf_we=wren and pc_we=1, each for exactly one cycle.
  - Next state FETCH if run=1, else IDLE.
- HALT:
  - halted=1; no strobes.
  - Exits only on reset.
- FAULT:
  - fault=1; no strobes.
  - Exits only on reset.
- Wait counter (8 bits):
  - Cleared to 0 on entry to FETCH or MEM; increments each cycle spent waiting in those states.
  - If ready=1, the ready wins, including when the count equals MEM_TIMEOUT.
  - If ready=0 while the count equals MEM_TIMEOUT → FAULT.
  - So at most MEM_TIMEOUT+1 cycles are spent in the state.
- Dropping run mid-instruction does not abort; the instruction completes through WB and the block then enters IDLE.
- Strobes other than ir_we are Moore-decoded from state and the decoder inputs.
- Reset (async, any state):
  - state=IDLE.
  - All strobes, halted and fault go to 0.
  - Wait counter and performance counters go to 0.

## Timing
- ALU instruction with zero-wait memory: 4 cycles (FETCH, DECODE, EXEC, WB).
- Load/store with zero-wait memory: 5 cycles.
- Each cycle of imem_ready or dmem_ready low adds 1 cycle.
- pc_we and rf_we rise together in WB and never in any other state.
- Reset asserted mid-MEM drops dmem_we/dmem_re asynchronously; no write is issued after reset.

## Configuration
- PERF_CNT_EN defined:
  - cycle_cnt increments every cycle the state is FETCH..WB.
  - instret_cnt increments in each WB cycle.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- PERF_CNT_EN undefined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Reset released, run=1, imem_ready=1, ALU instruction with wren=1 → states 1,2,3,5,1; rf_we and pc_we high only in cycle 4.
- Load with dmem_ready low for 3 cycles → MEM lasts 4 cycles with dmem_re=1, then WB; store with is_load=1 also set → dmem_we=1, dmem_re=0.
- MEM_TIMEOUT=4, imem_ready held 0 → FETCH for 5 cycles, then FAULT with fault=1 permanently; ready arriving on the 5th cycle → DECODE instead.
- is_halt decoded → HALT after DECODE; halted=1; run toggling has no effect until rst=0.
- run dropped during EXEC → WB completes, then IDLE; run=1 again → FETCH next cycle.
- PERF_CNT_EN: after 3 ALU instructions, instret_cnt=3 and cycle_cnt=12; preload near wrap → 0xFFFFFFFF rolls to 0. Without the macro, both read 0.
